// File: rtl/bin_to_gray_counter_if.sv
// Counter control and status bundle for the binary-to-Gray counter.
// The master drives the controls; the slave (the counter) drives the outputs.
interface bin_to_gray_counter_if #(
    parameter int WIDTH = 4
);
    logic             en;
    logic             up_dn;
    logic             load;
    logic [WIDTH-1:0] load_bin;
    logic [WIDTH-1:0] bin;
    logic [WIDTH-1:0] gray;
    logic             wrap;

    modport master (
        output en, up_dn, load, load_bin,
        input  bin, gray, wrap
    );

    modport slave (
        input  en, up_dn, load, load_bin,
        output bin, gray, wrap
    );
endinterface

// File: rtl/bin_to_gray_counter.sv
// Registered binary-to-Gray up/down counter.
// Keeps a binary count and publishes its Gray image straight from flops, so a
// count step flips exactly one output bit and the Gray bus never glitches.
// The Gray value is encoded from the next binary value, keeping bin and gray
// in the same cycle.
module bin_to_gray_counter #(
    parameter int WIDTH = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    bin_to_gray_counter_if.slave    bus
);
    localparam logic [WIDTH-1:0] ALL_ONES = '1;
    localparam logic [WIDTH-1:0] ONE      = WIDTH'(1);

    logic [WIDTH-1:0] bin_q,  bin_d;
    logic [WIDTH-1:0] gray_q, gray_d;
    logic             wrap_q, wrap_d;

    // Next-state: load beats count beats hold; wrap flags only boundary steps.
    always_comb begin
        bin_d  = bin_q;
        wrap_d = 1'b0;
        if (bus.load) begin
            bin_d = bus.load_bin;
        end else if (bus.en) begin
            if (bus.up_dn) begin
                bin_d  = bin_q + ONE;
                wrap_d = (bin_q == ALL_ONES);
            end else begin
                bin_d  = bin_q - ONE;
                wrap_d = (bin_q == '0);
            end
        end
        gray_d = bin_d ^ (bin_d >> 1);
    end

    // State registers; reset clears everything without waiting for a clock.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bin_q  <= '0;
            gray_q <= '0;
            wrap_q <= 1'b0;
        end else begin
            bin_q  <= bin_d;
            gray_q <= gray_d;
            wrap_q <= wrap_d;
        end
    end

    assign bus.bin  = bin_q;
    assign bus.gray = gray_q;
    assign bus.wrap = wrap_q;
endmodule

// File: tb/tb_bin_to_gray_counter.sv
// Directed self-checking bench for bin_to_gray_counter (WIDTH = 4).
module tb_bin_to_gray_counter;
    localparam int W = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_tot = 0;
    int   n_bad = 0;

    bin_to_gray_counter_if #(.WIDTH(W)) bus ();

    bin_to_gray_counter #(.WIDTH(W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tot++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    // Inputs are changed and outputs sampled 1 time unit after the rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic en, input logic up, input logic ld, input logic [W-1:0] lb);
        bus.en       = en;
        bus.up_dn    = up;
        bus.load     = ld;
        bus.load_bin = lb;
    endtask

    task automatic chk_out(input string tag, input logic [W-1:0] b, input logic [W-1:0] g, input logic w);
        chk({tag, ".bin"},  32'(bus.bin),  32'(b));
        chk({tag, ".gray"}, 32'(bus.gray), 32'(g));
        chk({tag, ".wrap"}, 32'(bus.wrap), 32'(w));
    endtask

    function automatic logic [W-1:0] g2b(input logic [W-1:0] g);
        logic [W-1:0] b;
        b[W-1] = g[W-1];
        for (int i = W - 2; i >= 0; i--) b[i] = b[i+1] ^ g[i];
        return b;
    endfunction

    initial begin
        #100000;
        $display("FAIL timeout: got running want finished");
        $fatal(1, "timeout");
    end

    initial begin
        logic [W-1:0] gseq [17];
        logic [W-1:0] prev_g;
        logic [W-1:0] m_bin;
        logic         m_wrap;
        logic [W-1:0] lb;
        logic         en, up, ld;

        gseq = '{4'h0, 4'h1, 4'h3, 4'h2, 4'h6, 4'h7, 4'h5, 4'h4,
                 4'hC, 4'hD, 4'hF, 4'hE, 4'hA, 4'hB, 4'h9, 4'h8, 4'h0};

        drive(1'b1, 1'b1, 1'b0, '0);
        #2;
        chk_out("reset", 4'h0, 4'h0, 1'b0);
        step();
        chk_out("reset_held", 4'h0, 4'h0, 1'b0);

        // Full up sweep from 0, released between edges.
        rst = 1'b0;
        prev_g = 4'h0;
        for (int k = 1; k <= 16; k++) begin
            step();
            chk($sformatf("sweep%0d.gray", k), 32'(bus.gray), 32'(gseq[k]));
            chk($sformatf("sweep%0d.bin", k),  32'(bus.bin),  32'(k % 16));
            chk($sformatf("sweep%0d.wrap", k), 32'(bus.wrap), 32'(k == 16));
            chk($sformatf("sweep%0d.onebit", k), 32'($countones(prev_g ^ bus.gray)), 32'd1);
            prev_g = bus.gray;
        end

        // Loading all-ones never flags wrap.
        drive(1'b1, 1'b1, 1'b1, 4'hF);
        step();
        chk_out("load_ones", 4'hF, 4'h8, 1'b0);

        // Down wrap from 0.
        drive(1'b0, 1'b0, 1'b1, 4'h0);
        step();
        chk_out("load_zero", 4'h0, 4'h0, 1'b0);
        drive(1'b1, 1'b0, 1'b0, '0);
        step();
        chk_out("down_wrap", 4'hF, 4'h8, 1'b1);
        step();
        chk_out("down_after", 4'hE, 4'h9, 1'b0);

        // Load beats enable.
        drive(1'b0, 1'b1, 1'b1, 4'h3);
        step();
        chk_out("load3", 4'h3, 4'h2, 1'b0);
        drive(1'b1, 1'b1, 1'b1, 4'hA);
        step();
        chk_out("load_prio", 4'hA, 4'hF, 1'b0);

        // Hold then reverse direction.
        drive(1'b0, 1'b1, 1'b1, 4'h5);
        step();
        chk_out("load5", 4'h5, 4'h7, 1'b0);
        drive(1'b0, 1'b0, 1'b0, '0);
        for (int k = 0; k < 3; k++) begin
            step();
            chk_out($sformatf("hold%0d", k), 4'h5, 4'h7, 1'b0);
        end
        drive(1'b1, 1'b1, 1'b0, '0);
        step();
        chk_out("rev_up", 4'h6, 4'h5, 1'b0);
        drive(1'b1, 1'b0, 1'b0, '0);
        step();
        chk_out("rev_dn1", 4'h5, 4'h7, 1'b0);
        step();
        chk_out("rev_dn2", 4'h4, 4'h6, 1'b0);

        // Reset mid-count at 0110, asserted between edges.
        drive(1'b0, 1'b1, 1'b1, 4'h5);
        step();
        drive(1'b1, 1'b1, 1'b0, '0);
        step();
        chk_out("pre_rst", 4'h6, 4'h5, 1'b0);
        #2;
        rst = 1'b1;
        #1;
        chk_out("async_rst", 4'h0, 4'h0, 1'b0);
        step();
        chk_out("rst_hold", 4'h0, 4'h0, 1'b0);
        #2;
        rst = 1'b0;
        step();
        chk_out("rst_release", 4'h1, 4'h1, 1'b0);

        // Random cycles against a reference count and a Gray decoder.
        m_bin = 4'h1;
        for (int k = 0; k < 100; k++) begin
            en = 1'($urandom_range(0, 3) != 0);
            up = 1'($urandom_range(0, 1));
            ld = 1'($urandom_range(0, 7) == 0);
            lb = W'($urandom_range(0, 15));
            drive(en, up, ld, lb);
            m_wrap = 1'b0;
            if (ld) begin
                m_bin = lb;
            end else if (en && up) begin
                m_wrap = (m_bin == 4'hF);
                m_bin  = m_bin + 4'h1;
            end else if (en) begin
                m_wrap = (m_bin == 4'h0);
                m_bin  = m_bin - 4'h1;
            end
            step();
            chk($sformatf("rnd%0d.bin", k),  32'(bus.bin),        32'(m_bin));
            chk($sformatf("rnd%0d.dec", k),  32'(g2b(bus.gray)),  32'(m_bin));
            chk($sformatf("rnd%0d.wrap", k), 32'(bus.wrap),       32'(m_wrap));
        end

        $display("test done: total=%0d bad=%0d", n_tot, n_bad);
        $finish;
    end
endmodule
